// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: stores to TXDATA queue bytes in a small FIFO,
// a serializer drains them onto tx, and STATUS reports FIFO/serializer state.
module mmio_uart_tx #(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [15:0] BASE_ADDR    = 16'hFF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] addr,
  input  logic [31:0] inputData,
  output logic [31:0] outputData,
  output logic        hit,
  output logic        tx
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [15:0]       STATUS_ADDR = BASE_ADDR + 16'd4;
  localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  DEPTH_CNT   = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              tx_q, tx_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;

  logic [7:0] fifo_mem [FIFO_DEPTH];

  logic        is_txdata, is_status;
  logic        full, empty, busy;
  logic        push_req, push, drop, clr, pop;
  logic        baud_done;
  logic [31:0] count_ext;
  logic [3:0]  count_field;
  logic        unused_bits;

  assign is_txdata = (addr == BASE_ADDR);
  assign is_status = (addr == STATUS_ADDR);
  assign full      = (count_q == DEPTH_CNT);
  assign empty     = (count_q == '0);
  assign busy      = (state_q != ST_IDLE);

  // Fullness is judged on the pre-edge count, so a simultaneous pop cannot rescue the byte.
  assign push_req  = en & is_txdata;
  assign push      = push_req & ~full;
  assign drop      = push_req & full;
  assign clr       = en & is_status & inputData[3];
  assign pop       = (state_q == ST_IDLE) & ~empty;
  assign baud_done = (baud_q == BAUD_LAST);

  assign unused_bits = ^{inputData[31:8]};

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (drop)     overflow_d = 1'b1;
    else if (clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= inputData[7:0];
  end

  // Serializer next-state logic.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          state_d = ST_START;
          baud_d  = '0;
          shreg_d = fifo_mem[rd_ptr_q];
        end
      end
      ST_START: begin
        if (baud_done) begin
          baud_d    = '0;
          bit_idx_d = 3'd0;
          state_d   = ST_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          baud_d  = '0;
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = ST_IDLE;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level for the current state; registered so tx lags the state by one cycle.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shreg_q[0];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      tx_q       <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      tx_q       <= tx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign count_ext   = 32'(count_q);
  assign count_field = (count_ext > 32'd15) ? 4'd15 : count_ext[3:0];

  assign tx         = tx_q;
  assign hit        = is_txdata | is_status;
  assign outputData = is_status ? {24'b0, count_field, overflow_q, busy, empty, full} : 32'b0;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=8); a line monitor
// decodes 8N1 frames from tx and records each byte with its start cycle.
module tb_mmio_uart_tx;
  localparam int          CPB    = 4;
  localparam int          DEPTH  = 8;
  localparam logic [15:0] TXDATA = 16'hFF00;
  localparam logic [15:0] STATUS = 16'hFF04;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] addr;
  logic [31:0] inputData;
  logic [31:0] outputData;
  logic        hit;
  logic        tx;

  int checks = 0;
  int errors = 0;

  int         cyc = 0;
  logic [7:0] rx_q [$];
  int         rx_t [$];
  int         frame_err = 0;

  mmio_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .BASE_ADDR   (16'hFF00)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .addr      (addr),
    .inputData (inputData),
    .outputData(outputData),
    .hit       (hit),
    .tx        (tx)
  );

  always #5 clk = ~clk;

  // Frame monitor: start bit seen at offset 0, data bit i sampled at 6+4i, stop at 38.
  initial begin : monitor
    bit         active;
    int         t0;
    int         off;
    logic [7:0] sh;
    active = 1'b0;
    t0     = 0;
    sh     = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst === 1'b1) begin
        active = 1'b0;
      end else if (!active) begin
        if (tx === 1'b0) begin
          active = 1'b1;
          t0     = cyc;
          sh     = '0;
        end
      end else begin
        off = cyc - t0;
        if (off >= 6 && off <= 34 && ((off - 6) % 4) == 0) sh[(off - 6) / 4] = tx;
        if (off == 38) begin
          if (tx !== 1'b1) frame_err++;
          rx_q.push_back(sh);
          rx_t.push_back(t0);
          active = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic store(input logic [15:0] a, input logic [31:0] d);
    en = 1'b1;
    addr = a;
    inputData = d;
    @(posedge clk);
    #1;
    en = 1'b0;
    addr = STATUS;
    inputData = 32'h0;
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (outputData[2:1] == 2'b01 && tx === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #2;
    end
  endtask

  task automatic test_reset;
    int high_cnt;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    checks++;
    if (outputData !== 32'h2) begin errors++; $display("FAIL reset_status: got %h expected 00000002", outputData); end
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    high_cnt = 0;
    repeat (50) begin
      @(posedge clk);
      #2;
      if (tx === 1'b1) high_cnt++;
    end
    checks++;
    if (high_cnt !== 50) begin errors++; $display("FAIL reset_idle_high: got %0d high cycles expected 50", high_cnt); end
    $display("test_reset: idle line held high for %0d cycles", high_cnt);
    // Async assertion in the middle of a start bit.
    store(TXDATA, 32'h0000_0000);
    idle_cycles(3);
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL reset_pre_start: got %b expected 0", tx); end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_async_tx: got %b expected 1", tx); end
    checks++;
    if (outputData !== 32'h2) begin errors++; $display("FAIL reset_async_status: got %h expected 00000002", outputData); end
    @(posedge clk);
    #2;
    rst = 1'b0;
    idle_cycles(2);
    rx_q.delete();
    rx_t.delete();
  endtask

  task automatic test_decode;
    addr = TXDATA;
    #1;
    checks++;
    if (hit !== 1'b1 || outputData !== 32'h0) begin errors++; $display("FAIL decode_txdata: got hit=%b data=%h expected hit=1 data=00000000", hit, outputData); end
    addr = STATUS;
    #1;
    checks++;
    if (hit !== 1'b1 || outputData !== 32'h2) begin errors++; $display("FAIL decode_status: got hit=%b data=%h expected hit=1 data=00000002", hit, outputData); end
    addr = 16'hFF08;
    #1;
    checks++;
    if (hit !== 1'b0 || outputData !== 32'h0) begin errors++; $display("FAIL decode_ff08: got hit=%b data=%h expected hit=0 data=00000000", hit, outputData); end
    addr = 16'hFF01;
    #1;
    checks++;
    if (hit !== 1'b0 || outputData !== 32'h0) begin errors++; $display("FAIL decode_ff01: got hit=%b data=%h expected hit=0 data=00000000", hit, outputData); end
    store(16'hFF08, 32'h0000_0055);
    idle_cycles(3);
    checks++;
    if (outputData !== 32'h2 || tx !== 1'b1) begin errors++; $display("FAIL decode_miss_store: got status=%h tx=%b expected 00000002 tx=1", outputData, tx); end
    $display("test_decode: status after missed store %h", outputData);
  endtask

  task automatic test_single_byte;
    logic       exp_tx;
    logic       exp_busy;
    logic [7:0] pat;
    logic [7:0] got;
    pat = 8'hA5;
    rx_q.delete();
    rx_t.delete();
    store(TXDATA, 32'h0000_00A5);
    for (int k = 0; k < 46; k++) begin
      if (k < 2)                 exp_tx = 1'b1;
      else if (k < 6)            exp_tx = 1'b0;
      else if (k < 38)           exp_tx = pat[(k - 6) / 4];
      else                       exp_tx = 1'b1;
      exp_busy = (k >= 1 && k <= 40);
      checks++;
      if (tx !== exp_tx) begin errors++; $display("FAIL single_tx[%0d]: got %b expected %b", k, tx, exp_tx); end
      checks++;
      if (outputData[2] !== exp_busy) begin errors++; $display("FAIL single_busy[%0d]: got %b expected %b", k, outputData[2], exp_busy); end
      @(posedge clk);
      #2;
    end
    got = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
    checks++;
    if (rx_q.size() != 1 || got !== 8'hA5) begin errors++; $display("FAIL single_rx: got %0d bytes first=%h expected 1 byte a5", rx_q.size(), got); end
    $display("test_single_byte: received %h", got);
  endtask

  task automatic test_back_to_back;
    bit         ok;
    logic [7:0] exp [3];
    exp[0] = 8'h11;
    exp[1] = 8'h22;
    exp[2] = 8'h33;
    rx_q.delete();
    rx_t.delete();
    store(TXDATA, 32'h11);
    checks++;
    if (outputData[7:4] !== 4'd1) begin errors++; $display("FAIL b2b_count0: got %0d expected 1", outputData[7:4]); end
    store(TXDATA, 32'h22);
    checks++;
    if (outputData[7:4] !== 4'd1) begin errors++; $display("FAIL b2b_count1: got %0d expected 1", outputData[7:4]); end
    store(TXDATA, 32'h33);
    checks++;
    if (outputData[7:4] !== 4'd2) begin errors++; $display("FAIL b2b_count2: got %0d expected 2", outputData[7:4]); end
    idle_cycles(1);
    checks++;
    if (outputData !== 32'h24) begin errors++; $display("FAIL b2b_status3: got %h expected 00000024", outputData); end
    wait_idle(400, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_drain: got timeout expected idle"); end
    checks++;
    if (rx_q.size() != 3) begin errors++; $display("FAIL b2b_nbytes: got %0d expected 3", rx_q.size()); end
    for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp[i]) begin errors++; $display("FAIL b2b_byte[%0d]: got %h expected %h", i, rx_q[i], exp[i]); end
    end
    for (int i = 1; i < 3 && i < rx_t.size(); i++) begin
      checks++;
      if (rx_t[i] - rx_t[i-1] != 41) begin errors++; $display("FAIL b2b_gap[%0d]: got %0d cycles expected 41", i, rx_t[i] - rx_t[i-1]); end
    end
    checks++;
    if (outputData !== 32'h2) begin errors++; $display("FAIL b2b_empty: got %h expected 00000002", outputData); end
    $display("test_back_to_back: %0d frames received", rx_q.size());
  endtask

  task automatic test_overflow;
    bit ok;
    rx_q.delete();
    rx_t.delete();
    for (int i = 0; i < 10; i++) begin
      store(TXDATA, 32'(i + 1));
      if (i == 8) begin
        checks++;
        if (outputData !== 32'h85) begin errors++; $display("FAIL ovf_full: got %h expected 00000085", outputData); end
      end
      if (i == 9) begin
        checks++;
        if (outputData !== 32'h8D) begin errors++; $display("FAIL ovf_set: got %h expected 0000008d", outputData); end
      end
    end
    wait_idle(1000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ovf_drain: got timeout expected idle"); end
    checks++;
    if (rx_q.size() != 9) begin errors++; $display("FAIL ovf_nbytes: got %0d expected 9", rx_q.size()); end
    for (int i = 0; i < 9 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== 8'(i + 1)) begin errors++; $display("FAIL ovf_byte[%0d]: got %h expected %h", i, rx_q[i], 8'(i + 1)); end
    end
    checks++;
    if (outputData !== 32'h0A) begin errors++; $display("FAIL ovf_sticky: got %h expected 0000000a", outputData); end
    store(STATUS, 32'hFFFF_FFF7);
    checks++;
    if (outputData !== 32'h0A) begin errors++; $display("FAIL ovf_noclear: got %h expected 0000000a", outputData); end
    store(STATUS, 32'h0000_0008);
    checks++;
    if (outputData !== 32'h02) begin errors++; $display("FAIL ovf_clear: got %h expected 00000002", outputData); end
    $display("test_overflow: %0d bytes sent, status after clear %h", rx_q.size(), outputData);
  endtask

  task automatic test_pointer_wrap;
    bit ok;
    int maxc;
    maxc = 0;
    rx_q.delete();
    rx_t.delete();
    for (int i = 0; i < 20; i++) begin
      store(TXDATA, 32'(8'(i * 37 + 5)));
      if (int'(outputData[7:4]) > maxc) maxc = int'(outputData[7:4]);
      repeat (39) begin
        @(posedge clk);
        #2;
        if (int'(outputData[7:4]) > maxc) maxc = int'(outputData[7:4]);
      end
    end
    wait_idle(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wrap_drain: got timeout expected idle"); end
    checks++;
    if (maxc != 1) begin errors++; $display("FAIL wrap_maxcount: got %0d expected 1", maxc); end
    checks++;
    if (rx_q.size() != 20) begin errors++; $display("FAIL wrap_nbytes: got %0d expected 20", rx_q.size()); end
    for (int i = 0; i < 20 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== 8'(i * 37 + 5)) begin errors++; $display("FAIL wrap_byte[%0d]: got %h expected %h", i, rx_q[i], 8'(i * 37 + 5)); end
    end
    $display("test_pointer_wrap: %0d bytes received, max count %0d", rx_q.size(), maxc);
  endtask

  task automatic test_reset_mid_frame;
    bit         ok;
    logic [7:0] got;
    rx_q.delete();
    rx_t.delete();
    store(TXDATA, 32'hC3);
    store(TXDATA, 32'h5A);
    store(TXDATA, 32'h77);
    idle_cycles(16);
    checks++;
    if (outputData !== 32'h24 || tx !== 1'b0) begin errors++; $display("FAIL midrst_pre: got status=%h tx=%b expected 00000024 tx=0", outputData, tx); end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL midrst_tx: got %b expected 1", tx); end
    checks++;
    if (outputData !== 32'h2) begin errors++; $display("FAIL midrst_status: got %h expected 00000002", outputData); end
    @(posedge clk);
    #2;
    rst = 1'b0;
    idle_cycles(60);
    checks++;
    if (rx_q.size() != 0 || tx !== 1'b1 || outputData !== 32'h2) begin errors++; $display("FAIL midrst_flushed: got %0d bytes tx=%b status=%h expected 0 bytes tx=1 00000002", rx_q.size(), tx, outputData); end
    store(TXDATA, 32'hABCD_EF96);
    wait_idle(200, ok);
    got = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
    checks++;
    if (!ok || rx_q.size() != 1 || got !== 8'h96) begin errors++; $display("FAIL midrst_after: got ok=%b %0d bytes first=%h expected 1 byte 96", ok, rx_q.size(), got); end
    $display("test_reset_mid_frame: post-reset byte %h", got);
  endtask

  initial begin
    rst = 1'b0;
    en = 1'b0;
    addr = STATUS;
    inputData = 32'h0;
    test_reset();
    test_decode();
    test_single_byte();
    test_back_to_back();
    test_overflow();
    test_pointer_wrap();
    test_reset_mid_frame();
    checks++;
    if (frame_err != 0) begin errors++; $display("FAIL stop_bits: got %0d bad stop bits expected 0", frame_err); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
